// File: rtl/trans_sched_if.sv
// Requester/packer bus for trans_sched: two framed requesters in, one beat stream out.
interface trans_sched_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_byt;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_byt;
  logic       req1_last;
  logic       req1_ready;
  logic       start;
  logic       byt;
  logic [7:0] data_out;
  logic [1:0] grant;
  logic       err_pad;
  logic       err_timeout;

  modport master (
    output req0_valid, req0_data, req0_byt, req0_last,
    output req1_valid, req1_data, req1_byt, req1_last,
    input  req0_ready, req1_ready,
    input  start, byt, data_out, grant, err_pad, err_timeout
  );

  modport slave (
    input  req0_valid, req0_data, req0_byt, req0_last,
    input  req1_valid, req1_data, req1_byt, req1_last,
    output req0_ready, req1_ready,
    output start, byt, data_out, grant, err_pad, err_timeout
  );
endinterface

// File: rtl/trans_sched.sv
// Two-requester frame scheduler: round-robin per frame, forwards byte/nibble beats,
// pads odd-nibble frames to a byte boundary and aborts frames that stall too long.
module trans_sched #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  trans_sched_if.slave bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned SW = 8;

  typedef enum logic [1:0] {IDLE, PASS, PAD} state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic            half_q, half_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic            start_q, start_d;
  logic            byt_q, byt_d;
  logic [DW-1:0]   data_q, data_d;
  logic            err_pad_q, err_pad_d;
  logic            err_timeout_q, err_timeout_d;

  logic            sel_valid;
  logic [DW-1:0]   sel_data;
  logic            sel_byt;
  logic            sel_last;
  logic            accept;

  // Granted requester's beat; the other requester is never looked at.
  assign sel_valid = grant_q[0] ? bus.req0_valid : (grant_q[1] & bus.req1_valid);
  assign sel_data  = grant_q[0] ? bus.req0_data  : bus.req1_data;
  assign sel_byt   = grant_q[0] ? bus.req0_byt   : bus.req1_byt;
  assign sel_last  = grant_q[0] ? bus.req0_last  : bus.req1_last;
  assign accept    = (state_q == PASS) && sel_valid;

  assign bus.req0_ready  = (state_q == PASS) && grant_q[0];
  assign bus.req1_ready  = (state_q == PASS) && grant_q[1];
  assign bus.start       = start_q;
  assign bus.byt         = byt_q;
  assign bus.data_out    = data_q;
  assign bus.grant       = grant_q;
  assign bus.err_pad     = err_pad_q;
  assign bus.err_timeout = err_timeout_q;

  always_comb begin
    logic            pick1;
    logic            half_nx;
    logic [SW-1:0]   stall_inc;
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    half_d        = half_q;
    stall_d       = stall_q;
    start_d       = 1'b0;
    byt_d         = 1'b0;
    data_d        = '0;
    err_pad_d     = 1'b0;
    err_timeout_d = 1'b0;
    pick1         = 1'b0;
    half_nx       = half_q;
    stall_inc     = stall_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          pick1        = bus.req1_valid && (!bus.req0_valid || !last_grant_q);
          state_d      = PASS;
          grant_d      = pick1 ? 2'b10 : 2'b01;
          last_grant_d = pick1;
          stall_d      = '0;
        end
      end
      PASS: begin
        if (accept) begin
          half_nx = half_q ^ ~sel_byt;
          start_d = 1'b1;
          byt_d   = sel_byt;
          data_d  = sel_byt ? sel_data : {4'h0, sel_data[3:0]};
          half_d  = half_nx;
          stall_d = '0;
          if (sel_last) begin
            grant_d = 2'b00;
            if (half_nx) begin
              state_d   = PAD;
              err_pad_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end else begin
          stall_inc = (stall_q == {SW{1'b1}}) ? stall_q : stall_q + SW'(1);
          stall_d   = stall_inc;
          // Abort: the frame is dropped, an odd nibble count still gets its pad.
          if (stall_inc >= SW'(TIMEOUT)) begin
            err_timeout_d = 1'b1;
            grant_d       = 2'b00;
            stall_d       = '0;
            if (half_q) begin
              state_d   = PAD;
              err_pad_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      PAD: begin
        start_d = 1'b1;
        half_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      grant_q       <= 2'b00;
      last_grant_q  <= 1'b1;
      half_q        <= 1'b0;
      stall_q       <= '0;
      start_q       <= 1'b0;
      byt_q         <= 1'b0;
      data_q        <= '0;
      err_pad_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      half_q        <= half_d;
      stall_q       <= stall_d;
      start_q       <= start_d;
      byt_q         <= byt_d;
      data_q        <= data_d;
      err_pad_q     <= err_pad_d;
      err_timeout_q <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_trans_sched.sv
// Directed bench for trans_sched: arbitration, byte/nibble frames, pad, timeout, reset.
module tb_trans_sched;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  trans_sched_if bus ();

  trans_sched #(.TIMEOUT(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic s, input logic b, input logic [7:0] d);
    chk({tag, ".start"}, 32'(bus.start), 32'(s));
    chk({tag, ".byt"}, 32'(bus.byt), 32'(b));
    chk({tag, ".data"}, 32'(bus.data_out), 32'(d));
  endtask

  task automatic chk_grant(input string tag, input logic [1:0] g, input logic r0, input logic r1);
    chk({tag, ".grant"}, 32'(bus.grant), 32'(g));
    chk({tag, ".rdy0"}, 32'(bus.req0_ready), 32'(r0));
    chk({tag, ".rdy1"}, 32'(bus.req1_ready), 32'(r1));
  endtask

  task automatic chk_err(input string tag, input logic p, input logic t);
    chk({tag, ".err_pad"}, 32'(bus.err_pad), 32'(p));
    chk({tag, ".err_timeout"}, 32'(bus.err_timeout), 32'(t));
  endtask

  task automatic set0(input logic v, input logic [7:0] d, input logic b, input logic l);
    bus.req0_valid = v; bus.req0_data = d; bus.req0_byt = b; bus.req0_last = l;
  endtask

  task automatic set1(input logic v, input logic [7:0] d, input logic b, input logic l);
    bus.req1_valid = v; bus.req1_data = d; bus.req1_byt = b; bus.req1_last = l;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset_n = 1'b0;
    set0(1'b0, 8'h00, 1'b0, 1'b0);
    set1(1'b0, 8'h00, 1'b0, 1'b0);

    // Contention from reset: req0 wins first, then req1
    set0(1'b1, 8'h12, 1'b1, 1'b0);
    set1(1'b1, 8'hAB, 1'b1, 1'b1);
    repeat (2) tick();
    chk_beat("rst", 1'b0, 1'b0, 8'h00);
    chk_grant("rst", 2'b00, 1'b0, 1'b0);
    chk_err("rst", 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk_grant("t1.g0", 2'b01, 1'b1, 1'b0);
    chk("t1.nostart", 32'(bus.start), 32'(0));
    tick();
    chk_beat("t1.b12", 1'b1, 1'b1, 8'h12);
    set0(1'b1, 8'h34, 1'b1, 1'b1);
    tick();
    chk_beat("t1.b34", 1'b1, 1'b1, 8'h34);
    chk_grant("t1.idle", 2'b00, 1'b0, 1'b0);
    set0(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk_grant("t1.g1", 2'b10, 1'b0, 1'b1);
    chk("t1.nostart2", 32'(bus.start), 32'(0));
    tick();
    chk_beat("t1.bAB", 1'b1, 1'b1, 8'hAB);
    chk_grant("t1.end", 2'b00, 1'b0, 1'b0);
    set1(1'b0, 8'h00, 1'b0, 1'b0);

    // Even nibble frame from req0: no pad
    set0(1'b1, 8'h05, 1'b0, 1'b0);
    tick();
    chk_grant("t2.g", 2'b01, 1'b1, 1'b0);
    tick();
    chk_beat("t2.n5", 1'b1, 1'b0, 8'h05);
    set0(1'b1, 8'h0C, 1'b0, 1'b1);
    tick();
    chk_beat("t2.nC", 1'b1, 1'b0, 8'h0C);
    chk_err("t2.end", 1'b0, 1'b0);
    chk_grant("t2.idle", 2'b00, 1'b0, 1'b0);
    set0(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk_beat("t2.nopad", 1'b0, 1'b0, 8'h00);
    chk_err("t2.nopad", 1'b0, 1'b0);

    // Odd nibble frame from req1: pad beat inserted
    set1(1'b1, 8'h03, 1'b0, 1'b0);
    tick();
    chk_grant("t3.g", 2'b10, 1'b0, 1'b1);
    tick();
    chk_beat("t3.n3", 1'b1, 1'b0, 8'h03);
    set1(1'b1, 8'h07, 1'b0, 1'b0);
    tick();
    chk_beat("t3.n7", 1'b1, 1'b0, 8'h07);
    set1(1'b1, 8'h09, 1'b0, 1'b1);
    tick();
    chk_beat("t3.n9", 1'b1, 1'b0, 8'h09);
    chk_grant("t3.pad", 2'b00, 1'b0, 1'b0);
    chk_err("t3.pad", 1'b1, 1'b0);
    set1(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk_beat("t3.padbeat", 1'b1, 1'b0, 8'h00);
    chk_err("t3.after", 1'b0, 1'b0);
    tick();
    chk_beat("t3.quiet", 1'b0, 1'b0, 8'h00);

    // Stall timeout after one nibble, req1 waiting throughout
    set0(1'b1, 8'h04, 1'b0, 1'b0);
    set1(1'b1, 8'h55, 1'b1, 1'b1);
    tick();
    chk_grant("t4.g", 2'b01, 1'b1, 1'b0);
    tick();
    chk_beat("t4.n4", 1'b1, 1'b0, 8'h04);
    set0(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i < 15; i++) begin
      chk("t4.stall.grant", 32'(bus.grant), 32'(2'b01));
      chk("t4.stall.to", 32'(bus.err_timeout), 32'(0));
      tick();
    end
    chk_grant("t4.s15", 2'b01, 1'b1, 1'b0);
    chk_err("t4.s15", 1'b0, 1'b0);
    tick();
    chk_err("t4.abort", 1'b1, 1'b1);
    chk_grant("t4.abort", 2'b00, 1'b0, 1'b0);
    chk("t4.abort.start", 32'(bus.start), 32'(0));
    tick();
    chk_beat("t4.padbeat", 1'b1, 1'b0, 8'h00);
    chk_err("t4.idle", 1'b0, 1'b0);
    chk_grant("t4.idle", 2'b00, 1'b0, 1'b0);
    tick();
    chk_grant("t4.g1", 2'b10, 1'b0, 1'b1);
    tick();
    chk_beat("t4.b55", 1'b1, 1'b1, 8'h55);
    set1(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset mid-frame after one nibble: outputs clear at once, no pad
    set0(1'b1, 8'h06, 1'b0, 1'b0);
    tick();
    chk_grant("t5.g", 2'b01, 1'b1, 1'b0);
    tick();
    chk_beat("t5.n6", 1'b1, 1'b0, 8'h06);
    set0(1'b1, 8'h21, 1'b1, 1'b1);
    reset_n = 1'b0;
    #1;
    chk_beat("t5.rst", 1'b0, 1'b0, 8'h00);
    chk_grant("t5.rst", 2'b00, 1'b0, 1'b0);
    chk_err("t5.rst", 1'b0, 1'b0);
    tick();
    reset_n = 1'b1;
    chk_beat("t5.rel", 1'b0, 1'b0, 8'h00);
    tick();
    chk_grant("t5.g2", 2'b01, 1'b1, 1'b0);
    chk_err("t5.nopad", 1'b0, 1'b0);
    tick();
    chk_beat("t5.b21", 1'b1, 1'b1, 8'h21);
    chk_err("t5.end", 1'b0, 1'b0);
    chk_grant("t5.idle", 2'b00, 1'b0, 1'b0);
    set0(1'b0, 8'h00, 1'b0, 1'b0);

    // Back-to-back frames with both requesters always valid
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    set0(1'b1, 8'hA1, 1'b1, 1'b1);
    set1(1'b1, 8'hB1, 1'b1, 1'b1);
    tick();
    chk_grant("t6.f0", 2'b01, 1'b1, 1'b0);
    tick();
    chk_beat("t6.bA1", 1'b1, 1'b1, 8'hA1);
    chk_grant("t6.i0", 2'b00, 1'b0, 1'b0);
    set0(1'b1, 8'hA2, 1'b1, 1'b1);
    tick();
    chk_grant("t6.f1", 2'b10, 1'b0, 1'b1);
    tick();
    chk_beat("t6.bB1", 1'b1, 1'b1, 8'hB1);
    chk_grant("t6.i1", 2'b00, 1'b0, 1'b0);
    tick();
    chk_grant("t6.f2", 2'b01, 1'b1, 1'b0);
    tick();
    chk_beat("t6.bA2", 1'b1, 1'b1, 8'hA2);
    set0(1'b0, 8'h00, 1'b0, 1'b0);
    set1(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    chk_beat("t6.quiet", 1'b0, 1'b0, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
